seven_seg_scan_ctrl: RTL and testbench

- Time-multiplexed scan controller for the 4-digit common-anode seven-segment display.
- Holds a 16-bit, 4-nibble display value and walks a digit index 0..3.
- Each cycle it presents one nibble on the digit output that feeds the seven-segment decoder, and drives the matching active-low anode.
- Display updates are double-buffered and take effect only at a frame boundary, so no frame is ever torn.

---
 rtl/seven_seg_scan_ctrl.sv | 127 ++++++++++++
 tb/tb_seven_seg_scan_ctrl.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scan_ctrl.sv
// seven_seg_scan_ctrl: time-multiplexed scan controller for a 4-digit
// common-anode seven-segment display. Walks digit index 0..3, one slot of
// REFRESH_COUNT cycles per digit, with a BLANK_CYCLES dead time at the start of
// each slot. Display updates are double-buffered and only take effect at the
// frame boundary (index wrapping 3 -> 0).
// Optional macro SEVEN_SEG_LEADING_ZERO_BLANK_EN: leading zero digits stay dark.
module seven_seg_scan_ctrl #(
    parameter int REFRESH_COUNT = 100000,
    parameter int BLANK_CYCLES  = 2000,
    parameter int CNT_W         = 17
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] value,
    input  logic        load,
    input  logic [3:0]  dp_in,
    input  logic [3:0]  blank,
    output logic [3:0]  digit,
    output logic [3:0]  an,
    output logic        dp,
    output logic        frame_done
);

    typedef enum logic {ST_BLANK, ST_SHOW} state_t;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_COUNT - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);
    // With no dead time the scan starts directly in SHOW.
    localparam state_t ST_RESET = (BLANK_CYCLES == 0) ? ST_SHOW : ST_BLANK;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    state_t           state_q, state_d;
    logic [15:0]      shadow_val_q, shadow_val_d;
    logic [3:0]       shadow_dp_q, shadow_dp_d;
    logic [15:0]      pend_val_q, pend_val_d;
    logic [3:0]       pend_dp_q, pend_dp_d;
    logic             pend_vld_q, pend_vld_d;
    logic [3:0]       digit_q, digit_d;
    logic [3:0]       an_q, an_d;
    logic             dp_q, dp_d;
    logic [3:0]       supp;
    logic             slot_wrap, frame_wrap, lit;

    assign slot_wrap  = (cnt_q == CNT_LAST);
    assign frame_wrap = slot_wrap && (idx_q == 2'd3);

`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
    // Digit i is dark when it and every higher nibble are zero; digit 0 always shows.
    assign supp = {shadow_val_q[15:12] == 4'h0,
                   shadow_val_q[15:8]  == 8'h0,
                   shadow_val_q[15:4]  == 12'h0,
                   1'b0};
`else
    assign supp = 4'b0000;
`endif

    // Next-state: slot counter, digit index, phase and the double buffer.
    always_comb begin
        cnt_d        = slot_wrap ? '0 : cnt_q + 1'b1;
        idx_d        = slot_wrap ? idx_q + 2'd1 : idx_q;
        state_d      = (cnt_d < CNT_BLANK) ? ST_BLANK : ST_SHOW;
        shadow_val_d = shadow_val_q;
        shadow_dp_d  = shadow_dp_q;
        pend_val_d   = pend_val_q;
        pend_dp_d    = pend_dp_q;
        pend_vld_d   = pend_vld_q;
        if (frame_wrap) begin
            // A load on the boundary cycle bypasses pending and goes live now.
            if (load) begin
                shadow_val_d = value;
                shadow_dp_d  = dp_in;
            end else if (pend_vld_q) begin
                shadow_val_d = pend_val_q;
                shadow_dp_d  = pend_dp_q;
            end
            pend_vld_d = 1'b0;
        end else if (load) begin
            pend_val_d = value;
            pend_dp_d  = dp_in;
            pend_vld_d = 1'b1;
        end
    end

    // Output decode for the current counter/index/phase, registered below.
    always_comb begin
        lit     = (state_q == ST_SHOW) && !blank[idx_q] && !supp[idx_q];
        digit_d = shadow_val_q[{idx_q, 2'b00} +: 4];
        an_d    = lit ? ~(4'b0001 << idx_q) : 4'b1111;
        dp_d    = lit ? ~shadow_dp_q[idx_q] : 1'b1;
    end

    // Scan state machine, buffers and registered display outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q        <= '0;
            idx_q        <= 2'd0;
            state_q      <= ST_RESET;
            shadow_val_q <= 16'h0;
            shadow_dp_q  <= 4'h0;
            pend_val_q   <= 16'h0;
            pend_dp_q    <= 4'h0;
            pend_vld_q   <= 1'b0;
            digit_q      <= 4'h0;
            an_q         <= 4'b1111;
            dp_q         <= 1'b1;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            state_q      <= state_d;
            shadow_val_q <= shadow_val_d;
            shadow_dp_q  <= shadow_dp_d;
            pend_val_q   <= pend_val_d;
            pend_dp_q    <= pend_dp_d;
            pend_vld_q   <= pend_vld_d;
            digit_q      <= digit_d;
            an_q         <= an_d;
            dp_q         <= dp_d;
        end
    end

    assign digit      = digit_q;
    assign an         = an_q;
    assign dp         = dp_q;
    assign frame_done = frame_wrap;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Bench for seven_seg_scan_ctrl with REFRESH_COUNT=8, BLANK_CYCLES=2.
// Loads push the frame they should appear in onto a queue; the checker pops
// them at frame start and compares every output cycle.
module tb_seven_seg_scan_ctrl;

    logic        clk, rst, load, dp, frame_done;
    logic [15:0] value;
    logic [3:0]  dp_in, blank, digit, an;

    seven_seg_scan_ctrl #(.REFRESH_COUNT(8), .BLANK_CYCLES(2), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .value(value), .load(load), .dp_in(dp_in),
        .blank(blank), .digit(digit), .an(an), .dp(dp), .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          tgt;
        logic [15:0] v;
        logic [3:0]  dpm;
        logic [3:0]  lit;
    } exp_t;

    typedef struct {
        logic [15:0] v;
        logic [3:0]  dpm;
        logic [3:0]  blk;
        logic [3:0]  lit;
    } vec_t;

`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
    localparam logic [3:0] LIT_0050 = 4'b0011;
    localparam logic [3:0] LIT_0000 = 4'b0001;
`else
    localparam logic [3:0] LIT_0050 = 4'b1111;
    localparam logic [3:0] LIT_0000 = 4'b1111;
`endif

    exp_t q[$];
    exp_t cur;
    vec_t vt[5];
    int   k;
    int   checks = 0;
    int   errors = 0;
    bit   run = 1'b0;
    logic [3:0] blk_s;
    logic [3:0] ld_lit;

    // k = position of the DUT slot counter since reset release
    always @(posedge clk or posedge rst) begin
        if (rst) k <= 0;
        else     k <= k + 1;
        blk_s <= blank;
    end

    task automatic cmp(input string nm, input logic [3:0] act, input logic [3:0] exp, input int pos);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s pos=%0d got=%h want=%h", nm, pos, act, exp);
        end
    endtask

    // Per-cycle checker, sampled away from the active edge.
    always @(negedge clk) begin
        if (run) begin
            if (rst || k == 0) begin
                q.delete();
                cur = '{tgt: 0, v: 16'h0, dpm: 4'h0, lit: 4'hF};
                cmp("rst_an", an, 4'hF, k);
                cmp("rst_dp", {3'b0, dp}, 4'h1, k);
                cmp("rst_digit", digit, 4'h0, k);
                cmp("rst_fd", {3'b0, frame_done}, 4'h0, k);
            end else begin
                int op, cnt, idx, fr;
                logic [3:0] e_an;
                logic e_dp;
                op  = k - 1;
                cnt = op % 8;
                idx = (op / 8) % 4;
                fr  = op / 32;
                if (op % 32 == 0)
                    while (q.size() > 0 && q[0].tgt <= fr) cur = q.pop_front();
                if (cnt >= 2 && cur.lit[idx] && !blk_s[idx]) begin
                    e_an = 4'hF & ~(4'b0001 << idx);
                    e_dp = ~cur.dpm[idx];
                end else begin
                    e_an = 4'hF;
                    e_dp = 1'b1;
                end
                cmp("an", an, e_an, op);
                cmp("dp", {3'b0, dp}, {3'b0, e_dp}, op);
                cmp("digit", digit, cur.v[idx*4 +: 4], op);
                cmp("frame_done", {3'b0, frame_done}, {3'b0, (k % 32) == 31}, k);
            end
            if (load && !rst)
                q.push_back('{tgt: k / 32 + 1, v: value, dpm: dp_in, lit: ld_lit});
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic go_to(input int p);
        for (int n = 0; n < 64 && (k % 32) != p; n++) tick();
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic [3:0] l);
        value  = v;
        dp_in  = d;
        ld_lit = l;
        load   = 1'b1;
        tick();
        load   = 1'b0;
    endtask

    initial begin
        vt[0] = '{v: 16'h1234, dpm: 4'b0010, blk: 4'b0000, lit: 4'b1111};
        vt[1] = '{v: 16'h0050, dpm: 4'b0000, blk: 4'b0000, lit: LIT_0050};
        vt[2] = '{v: 16'h0000, dpm: 4'b1111, blk: 4'b0000, lit: LIT_0000};
        vt[3] = '{v: 16'h1000, dpm: 4'b0000, blk: 4'b0000, lit: 4'b1111};
        vt[4] = '{v: 16'hF0A5, dpm: 4'b1001, blk: 4'b1000, lit: 4'b1111};
        rst = 1'b1; load = 1'b0; value = 16'h0; dp_in = 4'h0; blank = 4'h0; ld_lit = 4'hF;
        run = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (64) tick();

        // table vectors: load in slot 1, the following frame must show it
        for (int i = 0; i < 5; i++) begin
            blank = vt[i].blk;
            go_to(8);
            do_load(vt[i].v, vt[i].dpm, vt[i].lit);
            repeat (64) tick();
        end

        // two loads in one frame: last one wins
        blank = 4'h0;
        go_to(8);
        do_load(16'h1111, 4'h0, 4'hF);
        go_to(16);
        do_load(16'h9876, 4'h0, 4'hF);
        repeat (64) tick();

        // load on the frame_done cycle goes live in the very next frame
        go_to(31);
        do_load(16'hABCD, 4'b0101, 4'hF);
        repeat (64) tick();

        // blank index 2, then reset in the middle of its SHOW window
        blank = 4'b0100;
        go_to(20);
        repeat (2) tick();
        rst = 1'b1;
        repeat (2) tick();
        blank = 4'h0;
        rst = 1'b0;
        repeat (40) tick();

        run = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
